// File: rtl/decoder_select_arbiter.sv
// Round-robin arbiter that shares the registered 6-to-64 one-hot select among NREQ requesters.
// Optional build macro DEC_ARB_ABORT_EN adds an abort input that cuts a DRIVE phase short.
//
// state | meaning
// IDLE  | no select driven, accepting requests
// DRIVE | select driven for the latched hold length, no accepts
// GAP   | one forced all-zero cycle, accepting requests
module decoder_select_arbiter #(
  parameter int NREQ   = 4,
  parameter int HOLD_W = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [6*NREQ-1:0]   req_addr,
  output logic [NREQ-1:0]     req_ready,
  input  logic [HOLD_W-1:0]   hold_cycles,
`ifdef DEC_ARB_ABORT_EN
  input  logic                abort,
`endif
  output logic [63:0]         sel,
  output logic                sel_valid,
  output logic [IDW-1:0]      grant_id,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic [HOLD_W-1:0]  cnt_q;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [5:0]         win_addr;
  logic [IDW-1:0]     next_ptr;
  logic               accept;
  logic               abort_hit;
  int                 idx;

`ifdef DEC_ARB_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Rotating priority search starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
        win_addr  = req_addr[6*idx +: 6];
      end
    end
  end

  assign accept    = win_found && (state_q != DRIVE) && !rst;
  assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;
  assign next_ptr  = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
  assign busy      = (state_q == DRIVE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, GAP: state_d = accept ? DRIVE : IDLE;
      DRIVE:     if (abort_hit || cnt_q == '0) state_d = GAP;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      grant_id  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel       <= 64'd1 << win_addr;
        sel_valid <= 1'b1;
        grant_id  <= win_idx;
        ptr_q     <= next_ptr;
        // hold of 0 behaves as 1: counter holds the remaining cycles after this one
        cnt_q     <= (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);
      end else if (state_q == DRIVE) begin
        if (state_d == GAP) begin
          sel       <= '0;
          sel_valid <= 1'b0;
        end else begin
          cnt_q <= cnt_q - HOLD_W'(1);
        end
      end
    end
  end

endmodule
